// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants for the serial adder sequencer
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic S_A_LOAD = 1'b0;
  localparam logic S_A_ADD  = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request and serial datapath signals of the sequencer
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sum_bit;
  logic             carry_bit;
  logic             shift_cont;
  logic             s_A;
  logic             s_input_A;
  logic             s_input;
  logic             clr_carry;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  // master: requester plus serial datapath; slave: the sequencer
  modport master (
    output start, abort, op_a, op_b, sum_bit, carry_bit,
    input  shift_cont, s_A, s_input_A, s_input, clr_carry, busy, done, result, cout
  );

  modport slave (
    input  start, abort, op_a, op_b, sum_bit, carry_bit,
    output shift_cont, s_A, s_input_A, s_input, clr_carry, busy, done, result, cout
  );
endinterface

// File: rtl/serial_add_piso.sv
// rtl/serial_add_piso.sv - parallel-in, LSB-first serial-out operand register
module serial_add_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);
  logic [WIDTH-1:0] sh;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= d;
    end else if (shift) begin
      sh <= {1'b0, sh[WIDTH-1:1]};
    end
  end

  assign q0 = sh[0];
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequencer streaming an operand pair through a serial adder
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  serial_add_ctrl_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             a_bit;
  logic             b_bit;
  logic             accept;
  logic             in_load;
  logic             in_add;

  assign accept  = (state == ST_IDLE) && bus.start;
  assign in_load = (state == ST_LOAD);
  assign in_add  = (state == ST_ADD);

  serial_add_piso #(.WIDTH(WIDTH)) u_a_sh (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .shift (in_load),
    .d     (bus.op_a),
    .q0    (a_bit)
  );

  serial_add_piso #(.WIDTH(WIDTH)) u_b_sh (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .shift (in_load),
    .d     (bus.op_b),
    .q0    (b_bit)
  );

  // Sum bits collect in res_sh; result/cout only update on a completed add so an abort keeps them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      res_sh   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ST_ADD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_ADD: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            res_sh <= {bus.sum_bit, res_sh[WIDTH-1:1]};
            if (cnt == LAST) begin
              result_q <= {bus.sum_bit, res_sh[WIDTH-1:1]};
              cout_q   <= bus.carry_bit;
              state    <= ST_DONE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.shift_cont = in_load || in_add;
  assign bus.s_A        = in_add ? S_A_ADD : S_A_LOAD;
  assign bus.clr_carry  = in_load;
  assign bus.s_input_A  = in_load && a_bit;
  assign bus.s_input    = in_load && b_bit;
  assign bus.busy       = in_load || in_add;
  assign bus.done       = (state == ST_DONE);
  assign bus.result     = result_q;
  assign bus.cout       = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - sequencer driving behavioural serial adders at WIDTH 4 and 8
module tb_serial_add_ctrl;
  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_add_ctrl_if #(.WIDTH(4)) if4 ();
  serial_add_ctrl_if #(.WIDTH(8)) if8 ();

  serial_add_ctrl #(.WIDTH(4)) dut4 (.clock(clock), .reset(rst), .bus(if4));
  serial_add_ctrl #(.WIDTH(8)) dut8 (.clock(clock), .reset(rst), .bus(if8));

  always #5 clock = ~clock;

  // Behavioural shift-register adders: A accumulates the sum, B rotates, carry flop feeds back
  logic [3:0] ra4, rb4;
  logic       c4;
  assign if4.sum_bit   = ra4[0] ^ rb4[0] ^ c4;
  assign if4.carry_bit = (ra4[0] & rb4[0]) | (c4 & (ra4[0] ^ rb4[0]));
  always @(posedge clock or posedge rst) begin
    if (rst) begin
      ra4 <= '0; rb4 <= '0; c4 <= 1'b0;
    end else begin
      if (if4.clr_carry) c4 <= 1'b0;
      else if (if4.shift_cont) c4 <= if4.carry_bit;
      if (if4.shift_cont && !if4.s_A) begin
        ra4 <= {if4.s_input_A, ra4[3:1]};
        rb4 <= {if4.s_input, rb4[3:1]};
      end else if (if4.shift_cont) begin
        ra4 <= {if4.sum_bit, ra4[3:1]};
        rb4 <= {rb4[0], rb4[3:1]};
      end
    end
  end

  logic [7:0] ra8, rb8;
  logic       c8;
  assign if8.sum_bit   = ra8[0] ^ rb8[0] ^ c8;
  assign if8.carry_bit = (ra8[0] & rb8[0]) | (c8 & (ra8[0] ^ rb8[0]));
  always @(posedge clock or posedge rst) begin
    if (rst) begin
      ra8 <= '0; rb8 <= '0; c8 <= 1'b0;
    end else begin
      if (if8.clr_carry) c8 <= 1'b0;
      else if (if8.shift_cont) c8 <= if8.carry_bit;
      if (if8.shift_cont && !if8.s_A) begin
        ra8 <= {if8.s_input_A, ra8[7:1]};
        rb8 <= {if8.s_input, rb8[7:1]};
      end else if (if8.shift_cont) begin
        ra8 <= {if8.sum_bit, ra8[7:1]};
        rb8 <= {rb8[0], rb8[7:1]};
      end
    end
  end

  task automatic launch4(input logic [3:0] a, input logic [3:0] b);
    if4.op_a = a; if4.op_b = b; if4.start = 1'b1;
    @(posedge clock); #1 if4.start = 1'b0;
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    if8.op_a = a; if8.op_b = b; if8.start = 1'b1;
    @(posedge clock); #1 if8.start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    if4.op_a = 4'd5; if4.op_b = 4'd7; if4.start = 1'b1;
    if8.op_a = 8'd9; if8.op_b = 8'd9; if8.start = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({if4.shift_cont, if4.s_A, if4.s_input_A, if4.s_input, if4.clr_carry, if4.busy, if4.done, if4.cout, if4.result} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_w4: outputs got %b required all zero",
               {if4.shift_cont, if4.s_A, if4.s_input_A, if4.s_input, if4.clr_carry, if4.busy, if4.done, if4.cout, if4.result});
    end
    n_checks++;
    if ({if8.shift_cont, if8.s_A, if8.s_input_A, if8.s_input, if8.clr_carry, if8.busy, if8.done, if8.cout, if8.result} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_w8: outputs got %b required all zero",
               {if8.shift_cont, if8.s_A, if8.s_input_A, if8.s_input, if8.clr_carry, if8.busy, if8.done, if8.cout, if8.result});
    end
    if4.start = 1'b0; if8.start = 1'b0;
    rst = 1'b0;
    @(negedge clock);
    n_checks++;
    if (if4.busy !== 1'b0 || if8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy got %b/%b required 0/0", if4.busy, if8.busy);
    end
  endtask

  task automatic test_basic();
    logic [3:0] a = 4'd5;
    logic [3:0] b = 4'd7;
    logic [4:0] exp;
    @(negedge clock);
    launch4(a, b);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clock);
      exp[4] = (cyc <= 8);
      exp[3] = (cyc > 4) && (cyc <= 8);
      exp[2] = (cyc <= 4) ? a[cyc-1] : 1'b0;
      exp[1] = (cyc <= 4) ? b[cyc-1] : 1'b0;
      exp[0] = (cyc == 9);
      n_checks++;
      if ({if4.busy, if4.s_A, if4.s_input_A, if4.s_input, if4.done} !== exp) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: busy,s_A,s_input_A,s_input,done got %b required %b",
                 cyc, {if4.busy, if4.s_A, if4.s_input_A, if4.s_input, if4.done}, exp);
      end
    end
    n_checks++;
    if (if4.result !== 4'd12 || if4.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got %0d/%b required 12/0", if4.result, if4.cout);
    end
    @(negedge clock);
    n_checks++;
    if (if4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done got %b required 0", if4.done);
    end
  endtask

  task automatic test_abort();
    int  n;
    logic seen_done = 1'b0;
    @(negedge clock);
    launch4(4'd9, 4'd9);
    repeat (6) @(negedge clock);
    n_checks++;
    if (if4.s_A !== 1'b1 || if4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_add: s_A,busy got %b%b required 11", if4.s_A, if4.busy);
    end
    if4.abort = 1'b1;
    @(negedge clock);
    if4.abort = 1'b0;
    n_checks++;
    if (if4.shift_cont !== 1'b0 || if4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: shift_cont,busy got %b%b required 00", if4.shift_cont, if4.busy);
    end
    repeat (5) begin
      @(negedge clock);
      if (if4.done) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: done seen %b required 0", seen_done);
    end
    n_checks++;
    if (if4.result !== 4'd12 || if4.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_keep: got %0d/%b required 12/0", if4.result, if4.cout);
    end
    if4.abort = 1'b1;
    launch4(4'd2, 4'd3);
    if4.abort = 1'b0;
    @(negedge clock);
    n_checks++;
    if (if4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_start_wins: busy got %b required 1", if4.busy);
    end
    n = 1;
    while (!if4.done && n < 40) begin @(negedge clock); n++; end
    n_checks++;
    if (n !== 9 || if4.result !== 4'd5 || if4.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_result: latency %0d result %0d/%b required 9 5/0", n, if4.result, if4.cout);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clock);
    if4.op_a = 4'd15; if4.op_b = 4'd1; if4.start = 1'b1;
    @(posedge clock);
    #1 if4.op_a = 4'd9; if4.op_b = 4'd9;
    n = 0;
    while (!if4.done && n < 40) begin @(negedge clock); n++; end
    n_checks++;
    if (n !== 9 || if4.result !== 4'd0 || if4.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: latency %0d result %0d/%b required 9 0/1", n, if4.result, if4.cout);
    end
    @(negedge clock);
    n_checks++;
    if (if4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy got %b required 0", if4.busy);
    end
    if4.op_a = 4'd6; if4.op_b = 4'd3;
    @(posedge clock);
    #1 if4.start = 1'b0;
    n = 0;
    while (!if4.done && n < 40) begin @(negedge clock); n++; end
    n_checks++;
    if (n !== 9 || if4.result !== 4'd9 || if4.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: latency %0d result %0d/%b required 9 9/0", n, if4.result, if4.cout);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clock);
    launch4(4'd10, 4'd4);
    repeat (2) @(negedge clock);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({if4.shift_cont, if4.s_A, if4.s_input_A, if4.s_input, if4.clr_carry, if4.busy, if4.done, if4.cout, if4.result} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_mid: outputs got %b required all zero",
               {if4.shift_cont, if4.s_A, if4.s_input_A, if4.s_input, if4.clr_carry, if4.busy, if4.done, if4.cout, if4.result});
    end
    @(negedge clock);
    rst = 1'b0;
    launch4(4'd3, 4'd3);
    n = 0;
    while (!if4.done && n < 40) begin @(negedge clock); n++; end
    n_checks++;
    if (n !== 9 || if4.result !== 4'd6 || if4.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: latency %0d result %0d/%b required 9 6/0", n, if4.result, if4.cout);
    end
  endtask

  task automatic test_random();
    int         n;
    logic [3:0] a, b;
    logic [4:0] ref_sum;
    for (int k = 0; k < 10; k++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      ref_sum = 5'(a) + 5'(b);
      @(negedge clock);
      launch4(a, b);
      n = 0;
      while (!if4.done && n < 40) begin @(negedge clock); n++; end
      n_checks++;
      if (n !== 9 || {if4.cout, if4.result} !== ref_sum) begin
        n_fail++;
        $display("FAIL random_w4 %0d+%0d: latency %0d sum %0d required latency 9 sum %0d",
                 a, b, n, {if4.cout, if4.result}, ref_sum);
      end
    end
  endtask

  task automatic test_width8();
    int         n;
    logic [7:0] a, b;
    logic [8:0] ref_sum;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 8'd200 : 8'($urandom_range(0, 255));
      b = (k == 0) ? 8'd100 : 8'($urandom_range(0, 255));
      ref_sum = 9'(a) + 9'(b);
      @(negedge clock);
      launch8(a, b);
      n = 0;
      while (!if8.done && n < 60) begin @(negedge clock); n++; end
      n_checks++;
      if (n !== 17 || {if8.cout, if8.result} !== ref_sum) begin
        n_fail++;
        $display("FAIL width8 %0d+%0d: latency %0d sum %0d required latency 17 sum %0d",
                 a, b, n, {if8.cout, if8.result}, ref_sum);
      end
    end
  endtask

  initial begin
    if4.start = 1'b0; if4.abort = 1'b0; if4.op_a = '0; if4.op_b = '0;
    if8.start = 1'b0; if8.abort = 1'b0; if8.op_a = '0; if8.op_b = '0;
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for the team's shift-register serial adder (two W-bit shift registers, a full adder, a carry flip-flop).
- Takes one parallel operand pair per request and streams both operands into the adder's registers LSB-first (LOAD phase), then shifts W add cycles (ADD phase).
- Collects the serial sum and final carry, then reports completion with a one-cycle done pulse.
- Sits between a parallel requester and the serial datapath; drives the datapath's shift enable, mode select and serial inputs.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  request; sampled only in IDLE
- abort  input  1  synchronous cancel of an in-flight operation
- op_a  input  WIDTH  operand A; captured on an accepted start
- op_b  input  WIDTH  operand B; captured on an accepted start
- sum_bit  input  1  datapath full-adder sum output (combinational)
- carry_bit  input  1  datapath full-adder carry output (combinational)
- shift_cont  output  1  datapath shift enable
- s_A  output  1  datapath mode: 0 = load from serial inputs, 1 = add/feedback
- s_input_A  output  1  serial bit into register A
- s_input  output  1  serial bit into register B
- clr_carry  output  1  synchronous clear of the datapath carry flip-flop
- busy  output  1  high in LOAD and ADD
- done  output  1  one-cycle pulse on completion
- result  output  WIDTH  sum; valid from done until the next accepted start
- cout  output  1  final carry; same validity as result

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, every output 0, internal operand and result registers 0.
- FSM states: IDLE, LOAD, ADD, DONE. Counter width is clog2(WIDTH).
- IDLE:
  - start=1 captures op_a/op_b into internal shift registers a_sh/b_sh, clears counter, goes to LOAD.
  - start while not in IDLE is ignored; there is no queuing.
- LOAD (exactly WIDTH cycles):
  - shift_cont=1, s_A=0, clr_carry=1, s_input_A=a_sh[0], s_input=b_sh[0].
  - Each edge shifts a_sh/b_sh right by one and increments the counter.
  - When counter==WIDTH-1: counter clears, state goes to ADD.
- ADD (exactly WIDTH cycles):
  - shift_cont=1, s_A=1, clr_carry=0; s_input_A and s_input are driven 0.
  - Each edge: result <= {sum_bit, result[WIDTH-1:1]}.
  - On the last edge (counter==WIDTH-1): cout <= carry_bit, state goes to DONE.
- DONE (1 cycle): done=1, shift_cont=0, busy=0; next state IDLE.
- Outputs shift_cont, s_A, s_input_A, s_input, clr_carry, busy and done are registered or Moore-decoded from state. None combinationally depends on start.
- Latency: start accepted at edge 0; busy during cycles 1..2W; done high in cycle 2W+1. A new start can be accepted in the cycle after DONE, so throughput is one operation per 2W+2 cycles.
- abort:
  - In LOAD or ADD: next edge goes to IDLE, shift_cont drops, no done pulse; result and cout keep their previous values.
  - In IDLE or DONE: no effect.
  - abort and start together in IDLE: start wins.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- Counter never exceeds WIDTH-1. Operand wrap-around is not checked: the sum is modulo 2^WIDTH and the overflow appears on cout.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, ADD=2'd2, DONE=2'd3)
  - the default WIDTH constant
  - the mode constants S_A_LOAD=0 and S_A_ADD=1
- One natural sub-module: serial_add_piso. It is a WIDTH-bit parallel-in/serial-out register with load and shift enables, instantiated twice for a_sh and b_sh.
- FSM, counter and result collection stay in serial_add_ctrl.

Test Plan:
- The bench instantiates a behavioural serial-adder datapath driven by this controller; WIDTH=4.
- Reset asserted at t=1, clock period 10; outputs checked 0 during reset; start during reset ignored.
- op_a=4'd5, op_b=4'd7, start for 1 cycle -> busy 8 cycles, s_A=0 for 4 then 1 for 4; s_input_A sequence 1,0,1,0; done in cycle 9; result=4'd12, cout=0.
- op_a=4'd15, op_b=4'd1 -> result=4'd0, cout=1; back-to-back: second start asserted in the cycle after done is accepted, and a start held high during busy is ignored.
- abort in ADD cycle 2 -> shift_cont=0 next cycle, no done pulse, result and cout keep the prior values (12/0).
- reset asserted asynchronously mid-LOAD (between clock edges) -> all outputs 0 immediately; a following op_a=4'd3, op_b=4'd3 gives result=4'd6, cout=0.
- WIDTH=8 regression: op_a=8'd200, op_b=8'd100 -> result=8'd44, cout=1, done exactly 17 cycles after start.
